// File: rtl/macc_pkg.sv
// Shared definitions for the MAC shift-chain sequencer and the chain registers it drives.
// Holds the sequencer state encoding and the per-register select codes that are broadcast on sel.
// Contents: state_t, sel_t, SEL_HOLD / SEL_LOAD / SEL_SHIFT.
package macc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef logic [1:0] sel_t;

    // Chain register select codes: keep value, parallel-load din0, shift in din1.
    localparam sel_t SEL_HOLD  = 2'b00;
    localparam sel_t SEL_LOAD  = 2'b01;
    localparam sel_t SEL_SHIFT = 2'b10;

endpackage

// File: rtl/macc_seq_cnt.sv
// Loadable down-counter holding the remaining shift count of the current sequence.
// Latency: load/decrement visible one cycle after the request; is_one decoded from the register.
// Ports: CLK, RST (sync, active-high), load/din, en (decrement), is_one flag.
module macc_seq_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] din,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= din;
        end else if (en) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/macc_seq_ctrl.sv
// Sequencer for a MAC shift chain: one LOAD cycle, len SHIFT cycles, one DONE pulse per start.
// Latency: start at t -> LOAD t+1, shifts t+2..t+1+len, done t+2+len; stall freezes SHIFT in place.
// Ports: CLK, RST (sync active-high), VDD/GND (supply ties, unused), start, len, stall,
//        [abort when MACC_SEQ_ABORT_EN is defined], sel, acc_clr, mac_en, busy, done.
module macc_seq_ctrl
    import macc_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VDD,
    input  logic             GND,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             stall,
`ifdef MACC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sel,
    output logic             acc_clr,
    output logic             mac_en,
    output logic             busy,
    output logic             done
);

    state_t state;
    state_t state_nxt;
    logic   cnt_load;
    logic   cnt_en;
    logic   cnt_is_one;
    logic   abort_act;

    // Supply pins only tie the macro to the rails; no logic depends on them.
    logic unused_supply;
    assign unused_supply = VDD ^ GND;

`ifdef MACC_SEQ_ABORT_EN
    // Abort only has meaning while the chain is being loaded or shifted.
    assign abort_act = abort && ((state == ST_LOAD) || (state == ST_SHIFT));
`else
    assign abort_act = 1'b0;
`endif

    macc_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .load   (cnt_load),
        .en     (cnt_en),
        .din    (len),
        .is_one (cnt_is_one)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs follow the registered state; stall and abort only qualify the
    // SHIFT/LOAD strobes so a frozen or abandoned cycle never moves the chain.
    always_comb begin
        state_nxt = state;
        sel       = SEL_HOLD;
        acc_clr   = 1'b0;
        mac_en    = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        cnt_load  = 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
                        // Zero-length request completes without touching the chain.
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                acc_clr = 1'b1;
                if (abort_act) begin
                    state_nxt = ST_IDLE;
                end else begin
                    sel       = SEL_LOAD;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort_act) begin
                    state_nxt = ST_IDLE;
                end else if (!stall) begin
                    sel    = SEL_SHIFT;
                    mac_en = 1'b1;
                    cnt_en = 1'b1;
                    if (cnt_is_one) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
